text_line_buffer: RTL and testbench



---
 rtl/text_line_buffer.sv | 151 +++++++++++++++
 tb/tb_text_line_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/text_line_buffer.sv
// rtl/text_line_buffer.sv - editable text line with frame-synchronous commit to the display side
//
// Ports:
//   clk         - system clock, rising edge
//   rst_n       - asynchronous active-low reset
//   char_in     - ASCII code offered by the front end
//   char_valid  - char_in is valid
//   char_ready  - block can accept a code this cycle (high in IDLE only)
//   frame_start - single-cycle pulse at vertical blank; publishes the working line
//   text        - committed packed line, newest character in [7:0]
//   length      - committed character count, 0..MAX_CHARS
//   dirty       - working line differs from the committed line
//   overflow    - one-cycle pulse when a printable character is dropped on a full line

module text_line_buffer #(
  parameter int MAX_CHARS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             char_in,
  input  logic                   char_valid,
  output logic                   char_ready,
  input  logic                   frame_start,
  output logic [MAX_CHARS*8-1:0] text,
  output logic [6:0]             length,
  output logic                   dirty,
  output logic                   overflow
);

  localparam int         W       = MAX_CHARS * 8;
  localparam logic [6:0] MAX_LEN = 7'(MAX_CHARS);

  localparam logic [7:0] CODE_BS    = 8'h08;
  localparam logic [7:0] CODE_CR    = 8'h0D;
  localparam logic [7:0] CODE_SPACE = 8'h20;
  localparam logic [7:0] CODE_TILDE = 8'h7E;

  typedef enum logic {
    ST_IDLE,
    ST_EXEC
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [7:0]   code_q;

  logic [W-1:0] wtext;
  logic [W-1:0] wtext_nxt;
  logic [6:0]   wlen;
  logic [6:0]   wlen_nxt;

  logic         is_printable;
  logic         is_backspace;
  logic         is_cr;
  logic         line_full;
  logic         line_empty;
  logic         accept;

  assign is_printable = (code_q >= CODE_SPACE) && (code_q <= CODE_TILDE);
  assign is_backspace = (code_q == CODE_BS);
  assign is_cr        = (code_q == CODE_CR);
  assign line_full    = (wlen >= MAX_LEN);
  assign line_empty   = (wlen == 7'd0);
  assign accept       = char_valid && char_ready;

  // State register and code latch. The code is captured only on a real
  // handshake, so char_valid during EXEC leaves code_q untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      code_q <= 8'h00;
    end else begin
      state <= state_nxt;
      if (accept) begin
        code_q <= char_in;
      end
    end
  end

  // Next-state, handshake and edit decode.
  always_comb begin
    state_nxt  = state;
    char_ready = 1'b0;
    overflow   = 1'b0;
    wtext_nxt  = wtext;
    wlen_nxt   = wlen;

    case (state)
      ST_IDLE: begin
        char_ready = 1'b1;
        if (char_valid) begin
          state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        state_nxt = ST_IDLE;
        if (is_printable) begin
          if (!line_full) begin
            // Shift older characters toward the high bytes; the new one
            // lands in byte 0. Vacated bytes above wlen stay zero.
            wtext_nxt = (wtext << 8) | W'(code_q);
            wlen_nxt  = wlen + 7'd1;
          end else begin
            overflow = 1'b1;
          end
        end else if (is_backspace) begin
          if (!line_empty) begin
            // Dropping the newest character; a zero byte fills the top so
            // the line stays zero-padded beyond wlen.
            wtext_nxt = wtext >> 8;
            wlen_nxt  = wlen - 7'd1;
          end
        end else if (is_cr) begin
          wtext_nxt = '0;
          wlen_nxt  = 7'd0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Working line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wtext <= '0;
      wlen  <= 7'd0;
    end else begin
      wtext <= wtext_nxt;
      wlen  <= wlen_nxt;
    end
  end

  // Committed line. Sampling the registered working values means an edit
  // executing in the same cycle as frame_start waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      text   <= '0;
      length <= 7'd0;
    end else if (frame_start) begin
      text   <= wtext;
      length <= wlen;
    end
  end

  assign dirty = (wtext != text) || (wlen != length);

endmodule

// File: tb/tb_text_line_buffer.sv
// tb/tb_text_line_buffer.sv - directed table-driven bench for text_line_buffer

module tb_text_line_buffer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  char_in;
  logic        char_valid;
  logic        char_ready;
  logic        frame_start;
  logic [79:0] text;
  logic [6:0]  length;
  logic        dirty;
  logic        overflow;

  int n_checks;
  int n_errors;

  text_line_buffer #(.MAX_CHARS(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_in     (char_in),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .frame_start (frame_start),
    .text        (text),
    .length      (length),
    .dirty       (dirty),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    bit          commit;
    logic [6:0]  exp_len;
    logic [79:0] exp_text;
    bit          exp_dirty;
    bit          exp_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [7:0] code, input bit commit,
                              input logic [6:0] exp_len, input logic [79:0] exp_text,
                              input bit exp_dirty, input bit exp_ovf);
    vec_t v;
    v.code      = code;
    v.commit    = commit;
    v.exp_len   = exp_len;
    v.exp_text  = exp_text;
    v.exp_dirty = exp_dirty;
    v.exp_ovf   = exp_ovf;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offers one code starting at a negedge; returns at the negedge after the
  // EXEC cycle, with the overflow level seen during EXEC.
  task automatic send(input logic [7:0] c, output logic ovf);
    @(negedge clk);
    check("ready_before_send", 80'(char_ready), 80'd1);
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clk);
    ovf        = overflow;
    char_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic commit();
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  logic [79:0] all_a;
  logic [79:0] nine_a;
  logic        ovf_seen;
  logic [5:0]  ready_hist;
  int          accepts;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    char_in     = 8'h00;
    char_valid  = 1'b0;
    frame_start = 1'b0;
    all_a       = {10{8'h41}};
    nine_a      = {8'h00, {9{8'h41}}};

    add(8'h48, 0, 7'd0,  80'h0,        1, 0);
    add(8'h69, 1, 7'd2,  80'h4869,     0, 0);
    add(8'h07, 1, 7'd2,  80'h4869,     0, 0);
    add(8'h08, 1, 7'd1,  80'h48,       0, 0);
    add(8'h08, 1, 7'd0,  80'h0,        0, 0);
    add(8'h08, 1, 7'd0,  80'h0,        0, 0);
    add(8'h41, 0, 7'd0,  80'h0,        1, 0);
    add(8'h42, 0, 7'd0,  80'h0,        1, 0);
    add(8'h43, 1, 7'd3,  80'h414243,   0, 0);
    add(8'h08, 1, 7'd2,  80'h4142,     0, 0);
    add(8'h5A, 0, 7'd2,  80'h4142,     1, 0);
    add(8'h0D, 1, 7'd0,  80'h0,        0, 0);
    for (int i = 0; i < 10; i++) add(8'h41, 0, 7'd0, 80'h0, 1, 0);
    add(8'h42, 1, 7'd10, all_a,        0, 1);
    add(8'h08, 1, 7'd9,  nine_a,       0, 0);
    add(8'h1B, 1, 7'd9,  nine_a,       0, 0);
    add(8'h0D, 1, 7'd0,  80'h0,        0, 0);

    repeat (3) @(negedge clk);
    check("reset_ready",    80'(char_ready), 80'd1);
    check("reset_length",   80'(length),     80'd0);
    check("reset_text",     text,            80'h0);
    check("reset_dirty",    80'(dirty),      80'd0);
    check("reset_overflow", 80'(overflow),   80'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      send(vecs[i].code, ovf_seen);
      check($sformatf("v%0d_overflow", i), 80'(ovf_seen), 80'(vecs[i].exp_ovf));
      if (vecs[i].commit) commit();
      check($sformatf("v%0d_length", i), 80'(length), 80'(vecs[i].exp_len));
      check($sformatf("v%0d_text", i),   text,        vecs[i].exp_text);
      check($sformatf("v%0d_dirty", i),  80'(dirty),  80'(vecs[i].exp_dirty));
    end

    // Handshake spacing: valid held for six cycles gives three accepts.
    @(negedge clk);
    char_in    = 8'h41;
    char_valid = 1'b1;
    accepts    = 0;
    for (int i = 0; i < 6; i++) begin
      ready_hist[5-i] = char_ready;
      if (char_ready) accepts++;
      @(negedge clk);
    end
    char_valid = 1'b0;
    check("hs_ready_pattern", 80'(ready_hist), 80'(6'b101010));
    check("hs_accepts",       80'(accepts),    80'd3);
    commit();
    check("hs_length", 80'(length), 80'd3);
    check("hs_text",   text,        80'h414141);
    send(8'h0D, ovf_seen);
    commit();
    check("hs_cleared", 80'(length), 80'd0);

    // frame_start lands on the EXEC cycle of "X": the pre-edit line commits.
    @(negedge clk);
    char_in    = 8'h58;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid  = 1'b0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("same_cycle_length", 80'(length), 80'd0);
    check("same_cycle_dirty",  80'(dirty),  80'd1);
    commit();
    check("next_frame_length", 80'(length), 80'd1);
    check("next_frame_text",   text,        80'h58);
    check("next_frame_dirty",  80'(dirty),  80'd0);

    // Asynchronous reset in the middle of EXEC with five committed chars.
    send(8'h0D, ovf_seen);
    send(8'h41, ovf_seen);
    send(8'h42, ovf_seen);
    send(8'h43, ovf_seen);
    send(8'h44, ovf_seen);
    send(8'h45, ovf_seen);
    commit();
    check("pre_reset_length", 80'(length), 80'd5);
    @(negedge clk);
    char_in    = 8'h46;
    char_valid = 1'b1;
    @(posedge clk);
    #2;
    check("mid_exec_ready", 80'(char_ready), 80'd0);
    rst_n = 1'b0;
    #1;
    check("async_length",   80'(length),     80'd0);
    check("async_text",     text,            80'h0);
    check("async_ready",    80'(char_ready), 80'd1);
    check("async_dirty",    80'(dirty),      80'd0);
    check("async_overflow", 80'(overflow),   80'd0);
    @(negedge clk);
    char_valid = 1'b0;
    rst_n      = 1'b1;
    send(8'h07, ovf_seen);
    check("bell_overflow", 80'(ovf_seen), 80'd0);
    check("bell_dirty",    80'(dirty),    80'd0);
    commit();
    check("bell_length", 80'(length), 80'd0);
    check("bell_text",   text,        80'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
